mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator/master side of the single-port word memory interface (CEN/WEN/A/D/Hold/Flush/Q, 1-cycle registered read).
- Sits between the pipeline MEM stage and the data memory.
- Converts byte/halfword/word loads and stores into word accesses: sub-word stores use read-modify-write, and loads are extracted with sign/zero extension.
- Propagates pipeline hold/flush to the memory and reports misaligned accesses.

Parameters:
ADDR_W, 32, byte address width on both sides
CHECK_ALIGN, 1, 1 = misaligned/invalid-size requests raise err and perform no access; 0 = low address bits are ignored

Ports:
clk  input  1  system clock, all state on posedge
nrst  input  1  asynchronous active-low reset
req_valid  input  1  pipeline request present; accepted when req_valid & ~busy & ~hold & ~flush
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = invalid
req_sext  input  1  loads: 1 = sign-extend, 0 = zero-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned
hold  input  1  pipeline stall; freezes unit and memory output
flush  input  1  pipeline flush; aborts outstanding operation
busy  output  1  unit cannot accept a request this cycle
rsp_valid  output  1  load data valid this cycle
rsp_rdata  output  32  extended load data; 0 when rsp_valid=0
err  output  1  one-cycle pulse: misaligned or invalid size
mem_cen  output  1  memory chip enable
mem_wen  output  1  memory write enable
mem_a  output  ADDR_W  word-aligned address, bits[1:0]=0
mem_d  output  32  memory write data
mem_hold  output  1  equals hold
mem_flush  output  1  equals flush & ~hold
mem_q  input  32  memory read data, valid the cycle after a CEN=1 read

Behaviour:
- Reset (nrst=0, async): state=IDLE; latched addr/size/sext/wdata=0; err=0. All outputs 0 (busy, rsp_valid, rsp_rdata, mem_cen, mem_wen, mem_a, mem_d). mem_hold and mem_flush follow inputs. Reset in any state abandons the operation and performs no write.
- Memory contract:
  - Q is registered.
  - A write and a read of the same word in the same cycle return the OLD word.
  - Q becomes X whenever CEN=0.
  - Hold takes priority over Flush.
  - Consequence: mem_cen must stay 1 with mem_wen=0 while hold is asserted in RESP/RMW.
- FSM states: IDLE, RESP (load data returning), RMW (merge and write back).
- IDLE, request accepted, legal, combinational drive in the same cycle:
  - Word store: mem_cen=1, mem_wen=1, mem_d=req_wdata. Stay in IDLE; 0 busy cycles; no rsp.
  - Load (any size): mem_cen=1, mem_wen=0. Latch addr[1:0], size, sext. Go to RESP.
  - Byte/half store: mem_cen=1, mem_wen=0. Latch addr, size, wdata. Go to RMW.
- Illegal request (CHECK_ALIGN=1): half with addr[0]=1, word with addr[1:0]!=0, or size=3.
  - No memory access (mem_cen=0). err=1 on the next cycle (registered). State stays IDLE.
- RESP (1 cycle), hold=0, flush=0:
  - rsp_valid=1; rsp_rdata = lane extracted from mem_q, extended per sext. Go to IDLE.
  - Load latency is 1 cycle from acceptance.
- RMW (1 cycle), hold=0, flush=0:
  - Drive mem_cen=1, mem_wen=1, mem_d = mem_q with the target lane replaced by the low byte/half of the latched wdata. Go to IDLE.
- Lanes are little-endian: byte k = bits[8k+7:8k] selected by addr[1:0]; half selected by addr[1].
- busy = (state != IDLE) | hold.
- Hold in RESP/RMW: state frozen; mem_cen=1, mem_wen=0, mem_hold=1; rsp_valid=0. The memory keeps Q, so the operation completes normally after hold drops.
- Hold in IDLE: no request accepted; mem_cen=0.
- Flush (hold=0):
  - In RESP/RMW: state goes to IDLE, rsp_valid=0, no write; mem_cen=1 and mem_wen=0 in that cycle.
  - In IDLE: the request is not accepted.
- hold and flush both asserted: hold wins.
- err and rsp_valid are never asserted together.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2.
  - FSM state encoding (IDLE/RESP/RMW).
  - Alignment-check function.
- Sub-module mem_lane_logic (combinational): load extract+extend and store merge, given addr[1:0], size, sext, word, wdata. Reused later by the fetch path.

Test Plan:
- Preload MEM[1]=0x8899AABB. Byte load addr 0x5 with sext=1 -> one cycle after accept rsp_valid=1, rsp_rdata=0xFFFFFFAA. With sext=0 -> 0x000000AA. Half load 0x6, sext=1 -> 0xFFFF8899.
- MEM[1]=0x8899AABB; byte store wdata 0x11 addr 0x6 -> read cycle (cen=1, wen=0, a=0x4), then RMW cycle with wen=1, mem_d=0x8811AABB; busy=1 for exactly 1 cycle. A following word load of 0x4 returns 0x8811AABB.
- Word store 0xDEADBEEF at 0x10 (busy never 1), next cycle word load 0x10 -> rsp_rdata=0xDEADBEEF.
- Half load addr 0x3 and word load addr 0x2 -> err pulses 1 cycle each; mem_cen=0 throughout; rsp_valid=0; memory unchanged.
- Load, then hold=1 for 3 cycles in RESP -> rsp_valid=0 and mem_cen=1/wen=0 during hold. rsp_valid=1 with correct data in the cycle after hold drops.
- flush=1 during RMW -> no write, state IDLE. Separately, nrst=0 asserted mid-RMW -> all outputs 0 immediately; memory word unchanged.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit and its lane logic.
//   - size encodings carried on req_size
//   - FSM state encoding of the access unit
//   - is_aligned(): legality of a (size, addr[1:0]) pair
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // ready for a new request
    ST_RESP = 2'd1,  // load data returning on mem_q
    ST_RMW  = 2'd2   // old word on mem_q, merge and write back
  } state_t;

  // A request is legal when its size is defined and its byte address is
  // naturally aligned to that size.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~addr_lo[0];
      SZ_WORD: is_aligned = (addr_lo == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_logic.sv
// Combinational byte-lane logic for a 32-bit little-endian word memory.
//   addr_lo    : byte offset within the word (addr[1:0])
//   size       : SZ_BYTE / SZ_HALF / SZ_WORD (other codes act as word)
//   sext       : 1 = sign-extend loads, 0 = zero-extend
//   word       : word read from memory
//   wdata      : right-aligned store data
//   load_data  : selected lane of word, extended to 32 bits
//   store_word : word with the target lane replaced by wdata
module mem_lane_logic
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  byte_lsb;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte k lives in bits [8k+7:8k]; halves are picked by addr[1] only, so
  // addr[0] is ignored for halfwords when alignment is not enforced.
  assign byte_lsb = {addr_lo, 3'b000};
  assign byte_sel = word[byte_lsb +: 8];
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  // NOTE: every output gets a default first so no path through the case
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    load_data  = word;
    store_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_data                  = {{24{sext & byte_sel[7]}}, byte_sel};
        store_word                 = word;
        store_word[byte_lsb +: 8]  = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{sext & half_sel[15]}}, half_sel};
        store_word = addr_lo[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      default: begin
        load_data  = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline MEM-stage initiator for a single-port word memory with a
// registered 1-cycle read. Turns byte/half/word loads and stores into word
// accesses (read-modify-write for sub-word stores), extends load data, and
// passes pipeline hold/flush through to the memory.
//   clk, nrst         : clock, asynchronous active-low reset
//   req_*             : pipeline request (valid, we, size, sext, addr, wdata)
//   hold, flush       : pipeline stall / abort
//   busy              : no request can be accepted this cycle
//   rsp_valid/rdata   : load result, 1 cycle after acceptance
//   err               : one-cycle pulse for a misaligned/invalid request
//   mem_cen/wen/a/d   : memory command, word-aligned address, write data
//   mem_hold/flush    : stall/abort forwarded to the memory
//   mem_q             : memory read data
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              hold,
  input  logic              flush,
  output logic              busy,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              err,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_d,
  output logic              mem_hold,
  output logic              mem_flush,
  input  logic [31:0]       mem_q
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [31:0]       wdata_q;

  logic        accept;
  logic        legal;
  logic        go;
  logic        sub_store;
  logic [31:0] lane_load;
  logic [31:0] lane_store;

  // Gating with nrst keeps every command output at 0 while reset is held,
  // even if the pipeline keeps presenting a request.
  assign accept    = nrst & req_valid & (state == ST_IDLE) & ~hold & ~flush;
  assign legal     = ~CHECK_ALIGN | is_aligned(req_size, req_addr[1:0]);
  assign go        = accept & legal;
  assign sub_store = req_we & ((req_size == SZ_BYTE) | (req_size == SZ_HALF));

  assign busy      = nrst & ((state != ST_IDLE) | hold);
  assign mem_hold  = hold;
  assign mem_flush = flush & ~hold;

  mem_lane_logic u_lane (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .sext       (sext_q),
    .word       (mem_q),
    .wdata      (wdata_q),
    .load_data  (lane_load),
    .store_word (lane_store)
  );

  // In RESP/RMW the memory stays enabled as a read of the same word: under
  // hold the memory keeps Q, and on flush nothing is written.
  always_comb begin
    mem_cen   = 1'b0;
    mem_wen   = 1'b0;
    mem_a     = '0;
    mem_d     = '0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          mem_cen = 1'b1;
          mem_wen = req_we & ~sub_store;
          mem_a   = {req_addr[ADDR_W-1:2], 2'b00};
          mem_d   = (req_we & ~sub_store) ? req_wdata : 32'd0;
        end
      end
      ST_RESP: begin
        mem_cen = 1'b1;
        mem_a   = {addr_q[ADDR_W-1:2], 2'b00};
        if (!hold && !flush) begin
          rsp_valid = 1'b1;
          rsp_rdata = lane_load;
        end
      end
      ST_RMW: begin
        mem_cen = 1'b1;
        mem_a   = {addr_q[ADDR_W-1:2], 2'b00};
        if (!hold && !flush) begin
          mem_wen = 1'b1;
          mem_d   = lane_store;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      err     <= 1'b0;
    end else begin
      err <= accept & ~legal;
      case (state)
        ST_IDLE: begin
          if (go) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            sext_q  <= req_sext;
            wdata_q <= req_wdata;
            if (!req_we)       state <= ST_RESP;
            else if (sub_store) state <= ST_RMW;
          end
        end
        ST_RESP, ST_RMW: begin
          // Flush also lands here: the operation is dropped without a write.
          if (!hold) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural single-port memory
// (registered read, old data on read-during-write, Q garbage when CEN=0,
// Q frozen under hold).
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req_valid, req_we, req_sext, hold, flush;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, rsp_valid, err, mem_cen, mem_wen, mem_hold, mem_flush;
  logic [31:0] rsp_rdata, mem_a, mem_d, mem_q;

  logic        preload = 1'b0;
  logic [31:0] mem [0:63];

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sext  (req_sext),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .hold      (hold),
    .flush     (flush),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .err       (err),
    .mem_cen   (mem_cen),
    .mem_wen   (mem_wen),
    .mem_a     (mem_a),
    .mem_d     (mem_d),
    .mem_hold  (mem_hold),
    .mem_flush (mem_flush),
    .mem_q     (mem_q)
  );

  always #5 clk = ~clk;

  // Memory model.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem[1] <= 32'h8899AABB;
      mem_q  <= 32'h5A5A5A5A;
    end else if (!mem_hold) begin
      if (mem_cen) begin
        mem_q <= mem[mem_a[7:2]];
        if (mem_wen) mem[mem_a[7:2]] <= mem_d;
      end else begin
        mem_q <= 32'h5A5A5A5A;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_sext  = sext;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = SZ_BYTE;
    req_sext  = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] exp);
    tick();
    drive(1'b0, size, sext, addr, 32'd0);
    @(negedge clk);
    check({tag, ".cen"}, 32'(mem_cen), 32'd1);
    check({tag, ".wen"}, 32'(mem_wen), 32'd0);
    check({tag, ".a"}, mem_a, addr & 32'hFFFF_FFFC);
    tick();
    idle();
    @(negedge clk);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rdata"}, rsp_rdata, exp);
    check({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic do_illegal(input string tag, input logic [1:0] size, input logic [31:0] addr);
    tick();
    drive(1'b0, size, 1'b0, addr, 32'd0);
    @(negedge clk);
    check({tag, ".cen"}, 32'(mem_cen), 32'd0);
    tick();
    idle();
    @(negedge clk);
    check({tag, ".err"}, 32'(err), 32'd1);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".cen_next"}, 32'(mem_cen), 32'd0);
    tick();
    @(negedge clk);
    check({tag, ".err_drop"}, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    hold    = 1'b0;
    flush   = 1'b0;
    preload = 1'b1;
    nrst    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;

    // Reset state, with a request presented and hold toggled.
    drive(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hCAFEF00D);
    @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rdata", rsp_rdata, 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.cen", 32'(mem_cen), 32'd0);
    check("rst.wen", 32'(mem_wen), 32'd0);
    check("rst.a", mem_a, 32'd0);
    check("rst.d", mem_d, 32'd0);
    hold = 1'b1;
    #1;
    check("rst.mem_hold", 32'(mem_hold), 32'd1);
    check("rst.busy_hold", 32'(busy), 32'd0);
    hold = 1'b0;
    idle();
    tick();
    nrst = 1'b1;

    // Loads with lane extraction and extension.
    do_load("ld_b_sx", SZ_BYTE, 1'b1, 32'h5, 32'hFFFFFFAA);
    do_load("ld_b_zx", SZ_BYTE, 1'b0, 32'h5, 32'h000000AA);
    do_load("ld_h_sx", SZ_HALF, 1'b1, 32'h6, 32'hFFFF8899);

    // Byte store through read-modify-write.
    tick();
    drive(1'b1, SZ_BYTE, 1'b0, 32'h6, 32'h00000011);
    @(negedge clk);
    check("sb.rd_cen", 32'(mem_cen), 32'd1);
    check("sb.rd_wen", 32'(mem_wen), 32'd0);
    check("sb.rd_a", mem_a, 32'h4);
    check("sb.rd_busy", 32'(busy), 32'd0);
    tick();
    idle();
    @(negedge clk);
    check("sb.rmw_busy", 32'(busy), 32'd1);
    check("sb.rmw_cen", 32'(mem_cen), 32'd1);
    check("sb.rmw_wen", 32'(mem_wen), 32'd1);
    check("sb.rmw_a", mem_a, 32'h4);
    check("sb.rmw_d", mem_d, 32'h8811AABB);
    tick();
    @(negedge clk);
    check("sb.done_busy", 32'(busy), 32'd0);
    check("sb.mem", mem[1], 32'h8811AABB);
    do_load("ld_w_after_sb", SZ_WORD, 1'b0, 32'h4, 32'h8811AABB);

    // Word store then back-to-back word load.
    tick();
    drive(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("sw.cen", 32'(mem_cen), 32'd1);
    check("sw.wen", 32'(mem_wen), 32'd1);
    check("sw.a", mem_a, 32'h10);
    check("sw.d", mem_d, 32'hDEADBEEF);
    check("sw.busy", 32'(busy), 32'd0);
    tick();
    drive(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    check("sw_ld.busy", 32'(busy), 32'd0);
    check("sw_ld.cen", 32'(mem_cen), 32'd1);
    check("sw_ld.wen", 32'(mem_wen), 32'd0);
    tick();
    idle();
    @(negedge clk);
    check("sw_ld.rsp_valid", 32'(rsp_valid), 32'd1);
    check("sw_ld.rdata", rsp_rdata, 32'hDEADBEEF);

    // Illegal requests.
    do_illegal("ill_h3", SZ_HALF, 32'h3);
    do_illegal("ill_w2", SZ_WORD, 32'h2);
    do_illegal("ill_sz3", SZ_BAD, 32'h0);
    check("ill.mem", mem[1], 32'h8811AABB);

    // Hold for three cycles in RESP.
    tick();
    drive(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    tick();
    idle();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold.rsp_valid", 32'(rsp_valid), 32'd0);
      check("hold.cen", 32'(mem_cen), 32'd1);
      check("hold.wen", 32'(mem_wen), 32'd0);
      check("hold.mem_hold", 32'(mem_hold), 32'd1);
      check("hold.busy", 32'(busy), 32'd1);
      tick();
    end
    hold = 1'b0;
    @(negedge clk);
    check("hold.rsp_after", 32'(rsp_valid), 32'd1);
    check("hold.rdata_after", rsp_rdata, 32'hDEADBEEF);

    // Flush in IDLE blocks acceptance.
    tick();
    flush = 1'b1;
    drive(1'b0, SZ_WORD, 1'b0, 32'h4, 32'd0);
    @(negedge clk);
    check("flush_idle.cen", 32'(mem_cen), 32'd0);
    check("flush_idle.mem_flush", 32'(mem_flush), 32'd1);
    tick();
    idle();
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle.rsp_valid", 32'(rsp_valid), 32'd0);
    check("flush_idle.err", 32'(err), 32'd0);

    // Flush during RMW: no write.
    tick();
    drive(1'b1, SZ_BYTE, 1'b0, 32'h4, 32'h00000077);
    @(negedge clk);
    tick();
    idle();
    flush = 1'b1;
    @(negedge clk);
    check("flush_rmw.cen", 32'(mem_cen), 32'd1);
    check("flush_rmw.wen", 32'(mem_wen), 32'd0);
    check("flush_rmw.rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_rmw.busy", 32'(busy), 32'd0);
    check("flush_rmw.cen_after", 32'(mem_cen), 32'd0);
    check("flush_rmw.mem", mem[1], 32'h8811AABB);

    // Reset asserted mid-RMW.
    tick();
    drive(1'b1, SZ_HALF, 1'b0, 32'h4, 32'h00001234);
    @(negedge clk);
    tick();
    idle();
    @(negedge clk);
    check("rst_rmw.busy_before", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    check("rst_rmw.busy", 32'(busy), 32'd0);
    check("rst_rmw.cen", 32'(mem_cen), 32'd0);
    check("rst_rmw.wen", 32'(mem_wen), 32'd0);
    check("rst_rmw.a", mem_a, 32'd0);
    check("rst_rmw.d", mem_d, 32'd0);
    check("rst_rmw.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rmw.err", 32'(err), 32'd0);
    tick();
    tick();
    nrst = 1'b1;
    @(negedge clk);
    check("rst_rmw.mem", mem[1], 32'h8811AABB);
    do_load("ld_after_rst", SZ_HALF, 1'b0, 32'h6, 32'h00008811);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
